muldiv_seq: RTL and testbench

Sequencer and HI/LO register owner for the multiply/divide path. Accepts MULT/DIV requests from the control unit and issues a one-cycle start pulse to the mult or div unit. It waits for that unit's stop flag, then latches its hi/lo outputs into the architectural HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads, and drives a busy flag that the control unit uses to stall.

---
 rtl/muldiv_seq_if.sv | 52 +++++
 rtl/muldiv_seq.sv | 163 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: bundles the request, unit-handshake and HI/LO signals of the
// multiply/divide sequencer.
//   slave  : the sequencer's view (requests and unit results in, starts,
//            status and HI/LO out).
//   master : the control unit / mult / div side (the mirror of slave).
// Signals:
//   op_mult, op_div, mthi, mtlo, wr_data, hilo_sel    control-unit requests
//   mult_hi, mult_lo, mult_stop                       mult unit results
//   div_hi, div_lo, div_stop, div_zero                div unit results
//   mult_start, div_start                             one-cycle unit starts
//   busy, done, dz_err, to_err                        sequencer status
//   hi, lo, rd_data                                   architectural HI/LO
interface muldiv_seq_if;
  logic        op_mult;
  logic        op_div;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        hilo_sel;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_stop;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_stop;
  logic        div_zero;
  logic        mult_start;
  logic        div_start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;
  logic        dz_err;
  logic        to_err;

  modport slave (
    input  op_mult, op_div, mthi, mtlo, wr_data, hilo_sel,
    input  mult_hi, mult_lo, mult_stop,
    input  div_hi, div_lo, div_stop, div_zero,
    output mult_start, div_start, busy, done,
    output hi, lo, rd_data, dz_err, to_err
  );

  modport master (
    output op_mult, op_div, mthi, mtlo, wr_data, hilo_sel,
    output mult_hi, mult_lo, mult_stop,
    output div_hi, div_lo, div_stop, div_zero,
    input  mult_start, div_start, busy, done,
    input  hi, lo, rd_data, dz_err, to_err
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer and HI/LO register owner for the multiply/divide path.
// Accepts MULT/DIV requests in IDLE, pulses the matching unit's start for one
// cycle, waits (bounded by TIMEOUT cycles) for the unit's stop flag, then
// latches the unit's hi/lo into HI/LO. Also services MTHI/MTLO writes and the
// combinational MFHI/MFLO read port.
// Parameters:
//   TIMEOUT  max WAIT cycles before abort with to_err (1..256)
// Ports:
//   clk      clock
//   Reset    synchronous, active-high reset
//   bus      muldiv_seq_if.slave (requests, unit handshakes, HI/LO, status)
module muldiv_seq #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         Reset,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START_M,
    WAIT_M,
    START_D,
    WAIT_D
  } state_t;

  // The counter is tested before its increment lands, so the last WAIT
  // cycle allowed is the one where it still reads TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        mult_start_q, mult_start_d;
  logic        div_start_q, div_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_err_q, dz_err_d;
  logic        to_err_q, to_err_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      dz_err_q     <= 1'b0;
      to_err_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      dz_err_q     <= dz_err_d;
      to_err_q     <= to_err_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dz_err_d     = dz_err_q;
    to_err_d     = to_err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.op_mult) begin
          state_d      = START_M;
          mult_start_d = 1'b1;
          busy_d       = 1'b1;
          dz_err_d     = 1'b0;
          to_err_d     = 1'b0;
          cnt_d        = '0;
        end else if (bus.op_div) begin
          state_d     = START_D;
          div_start_d = 1'b1;
          busy_d      = 1'b1;
          dz_err_d    = 1'b0;
          to_err_d    = 1'b0;
          cnt_d       = '0;
        end else begin
          if (bus.mthi) hi_d = bus.wr_data;
          if (bus.mtlo) lo_d = bus.wr_data;
        end
      end

      // The stop flag is not looked at here: it may still hold the previous
      // operation's level until the unit has loaded the new start.
      START_M: state_d = WAIT_M;
      START_D: state_d = WAIT_D;

      WAIT_M: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.mult_stop) begin
          hi_d    = bus.mult_hi;
          lo_d    = bus.mult_lo;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      WAIT_D: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.div_stop) begin
          if (bus.div_zero) begin
            dz_err_d = 1'b1;
          end else begin
            hi_d = bus.div_hi;
            lo_d = bus.div_lo;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          to_err_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.mult_start = mult_start_q;
  assign bus.div_start  = div_start_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.dz_err     = dz_err_q;
  assign bus.to_err     = to_err_q;
  // No write bypass: a read in the cycle of an MTHI/MTLO sees the old value.
  assign bus.rd_data    = bus.hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_seq_if bus();

  muldiv_seq #(.TIMEOUT(64)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // kind: 0 mult, 1 div, 2 mthi, 3 mtlo, 4 mthi+mtlo
  // a/b : mult operands | div remainder/quotient | a = wr_data for moves
  // lat : unit cycles from load to stop (-1 = never stops)
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        dz;
    bit          extra;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  // ---------------- unit stubs (shared Reset) ----------------
  int          mult_lat = -1;
  int          div_lat = -1;
  logic [63:0] mult_res = '0;
  logic [31:0] div_rem = '0;
  logic [31:0] div_quo = '0;
  logic        div_zero_v = 1'b0;
  int          mcnt = -1;
  int          dcnt = -1;

  // Unit loads at the edge ending the start cycle; stop rises lat cycles later.
  always @(negedge clk) begin
    if (Reset) begin
      mcnt = -1;
      bus.mult_stop = 1'b0;
    end else if (bus.mult_start) begin
      bus.mult_stop = 1'b0;
      bus.mult_hi = mult_res[63:32];
      bus.mult_lo = mult_res[31:0];
      mcnt = mult_lat;
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) bus.mult_stop = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (Reset) begin
      dcnt = -1;
      bus.div_stop = 1'b0;
      bus.div_zero = 1'b0;
    end else if (bus.div_start) begin
      bus.div_stop = 1'b0;
      bus.div_zero = 1'b0;
      bus.div_hi = div_rem;
      bus.div_lo = div_quo;
      dcnt = div_lat;
    end else if (dcnt > 0) begin
      dcnt = dcnt - 1;
      if (dcnt == 0) begin
        bus.div_stop = 1'b1;
        bus.div_zero = div_zero_v;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int n;
    int ms;
    int ds;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    old_hi = bus.hi;
    old_lo = bus.lo;
    n = 0;
    if (v.kind <= 1) begin
      if (v.kind == 0) begin
        sa = $signed(v.a);
        sb = $signed(v.b);
        mult_res = sa * sb;
        mult_lat = v.lat;
        bus.op_mult = 1'b1;
        if (v.extra) begin
          bus.op_div = 1'b1;
          bus.mthi = 1'b1;
          bus.mtlo = 1'b1;
          bus.wr_data = 32'hBAD0BAD0;
        end
      end else begin
        div_rem = v.a;
        div_quo = v.b;
        div_zero_v = v.dz;
        div_lat = v.lat;
        bus.op_div = 1'b1;
      end
      step();
      bus.op_mult = 1'b0;
      bus.op_div = 1'b0;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      ms = int'(bus.mult_start);
      ds = int'(bus.div_start);
      chk({tag, ":busy_after_req"}, 32'(bus.busy), 32'd1);
      if (v.extra) chk({tag, ":move_dropped"}, bus.hi, old_hi);
      while (bus.done !== 1'b1 && n < 200) begin
        step();
        n++;
        ms += int'(bus.mult_start);
        ds += int'(bus.div_start);
      end
      chk({tag, ":latency"}, 32'(n), 32'(v.exp_cyc));
      chk({tag, ":mult_start_pulses"}, 32'(ms), (v.kind == 0) ? 32'd1 : 32'd0);
      chk({tag, ":div_start_pulses"}, 32'(ds), (v.kind == 1) ? 32'd1 : 32'd0);
    end else begin
      bus.wr_data = v.a;
      bus.mthi = (v.kind == 2 || v.kind == 4);
      bus.mtlo = (v.kind == 3 || v.kind == 4);
      bus.hilo_sel = (v.kind != 3);
      #1;
      chk({tag, ":no_bypass"}, bus.rd_data, (v.kind == 3) ? old_lo : old_hi);
      step();
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      chk({tag, ":no_done_on_move"}, 32'(bus.done), 32'd0);
    end
    chk({tag, ":hi"}, bus.hi, v.exp_hi);
    chk({tag, ":lo"}, bus.lo, v.exp_lo);
    chk({tag, ":dz_err"}, 32'(bus.dz_err), 32'(v.exp_dz));
    chk({tag, ":to_err"}, 32'(bus.to_err), 32'(v.exp_to));
    chk({tag, ":busy_end"}, 32'(bus.busy), 32'd0);
    bus.hilo_sel = 1'b1;
    #1;
    chk({tag, ":rd_hi"}, bus.rd_data, v.exp_hi);
    bus.hilo_sel = 1'b0;
    #1;
    chk({tag, ":rd_lo"}, bus.rd_data, v.exp_lo);
    step();
    chk({tag, ":done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  vec_t tbl[12];

  // Reference state for the random phase, updated from the operation rules.
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;
  logic        ref_dz;
  logic        ref_to;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nd;
    logic [31:0] old_hi;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    vec_t v;

    bus.op_mult = 1'b0;
    bus.op_div = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    bus.wr_data = '0;
    bus.hilo_sel = 1'b0;

    Reset = 1'b1;
    repeat (3) step();
    chk("reset:hi", bus.hi, 32'd0);
    chk("reset:lo", bus.lo, 32'd0);
    chk("reset:rd", bus.rd_data, 32'd0);
    chk("reset:busy", 32'(bus.busy), 32'd0);
    chk("reset:done", 32'(bus.done), 32'd0);
    chk("reset:mult_start", 32'(bus.mult_start), 32'd0);
    chk("reset:div_start", 32'(bus.div_start), 32'd0);
    chk("reset:dz_err", 32'(bus.dz_err), 32'd0);
    chk("reset:to_err", 32'(bus.to_err), 32'd0);
    Reset = 1'b0;
    step();

    //            kind a             b             lat dz    ex  exp_hi        exp_lo        dz    to    cyc
    tbl[0]  = '{0, 32'd7,        32'hFFFFFFFD, 32, 1'b0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 33};
    tbl[1]  = '{1, 32'd1,        32'd3,        10, 1'b0, 0, 32'd1,        32'd3,        1'b0, 1'b0, 11};
    tbl[2]  = '{1, 32'h0000AAAA, 32'h0000BBBB, 4,  1'b1, 0, 32'd1,        32'd3,        1'b1, 1'b0, 5};
    tbl[3]  = '{0, 32'd2,        32'd3,        5,  1'b0, 0, 32'd0,        32'd6,        1'b0, 1'b0, 6};
    tbl[4]  = '{2, 32'hDEADBEEF, 32'd0,        0,  1'b0, 0, 32'hDEADBEEF, 32'd6,        1'b0, 1'b0, 0};
    tbl[5]  = '{3, 32'h12345678, 32'd0,        0,  1'b0, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 0};
    tbl[6]  = '{0, 32'd5,        32'd5,        -1, 1'b0, 0, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b1, 65};
    tbl[7]  = '{0, 32'h00010000, 32'h00010000, 64, 1'b0, 0, 32'd1,        32'd0,        1'b0, 1'b0, 65};
    tbl[8]  = '{0, 32'd3,        32'd3,        65, 1'b0, 0, 32'd1,        32'd0,        1'b0, 1'b1, 65};
    tbl[9]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  1'b0, 1, 32'd0,        32'd1,        1'b0, 1'b0, 4};
    tbl[10] = '{4, 32'h0F0F0F0F, 32'd0,        0,  1'b0, 0, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, 1'b0, 0};
    tbl[11] = '{1, 32'd5,        32'd6,        1,  1'b0, 0, 32'd5,        32'd6,        1'b0, 1'b0, 2};

    for (int i = 0; i < 12; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // mthi while busy is ignored
    old_hi = bus.hi;
    mult_res = 64'd20;
    mult_lat = 20;
    bus.op_mult = 1'b1;
    step();
    bus.op_mult = 1'b0;
    repeat (3) step();
    bus.mthi = 1'b1;
    bus.wr_data = 32'h55555555;
    step();
    bus.mthi = 1'b0;
    chk("busy_mthi:hi_kept", bus.hi, old_hi);
    n = 4;
    while (bus.done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("busy_mthi:latency", 32'(n), 32'd21);
    chk("busy_mthi:hi", bus.hi, 32'd0);
    chk("busy_mthi:lo", bus.lo, 32'd20);
    step();

    // reset 10 cycles into a multiply
    sa = 64'sd7;
    sb = -64'sd3;
    mult_res = sa * sb;
    mult_lat = 32;
    bus.op_mult = 1'b1;
    step();
    bus.op_mult = 1'b0;
    repeat (10) step();
    Reset = 1'b1;
    step();
    chk("midreset:hi", bus.hi, 32'd0);
    chk("midreset:lo", bus.lo, 32'd0);
    chk("midreset:busy", 32'(bus.busy), 32'd0);
    chk("midreset:done", 32'(bus.done), 32'd0);
    chk("midreset:mult_start", 32'(bus.mult_start), 32'd0);
    Reset = 1'b0;
    nd = 0;
    repeat (40) begin
      step();
      nd += int'(bus.done);
    end
    chk("midreset:no_done", 32'(nd), 32'd0);
    do_op(tbl[0], "post_reset");

    // randomized operations against the reference model
    ref_hi = 32'hFFFFFFFF;
    ref_lo = 32'hFFFFFFEB;
    ref_dz = 1'b0;
    ref_to = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v.kind = int'($urandom_range(0, 4));
      v.a = $urandom;
      v.b = $urandom;
      v.lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 40));
      v.dz = (v.kind == 1) && ($urandom_range(0, 3) == 0);
      v.extra = (v.kind == 0) && ($urandom_range(0, 3) == 0);
      v.exp_cyc = 0;
      if (v.kind <= 1) begin
        ref_dz = 1'b0;
        ref_to = 1'b0;
        if (v.lat + 1 > 65) begin
          ref_to = 1'b1;
          v.exp_cyc = 65;
        end else begin
          v.exp_cyc = v.lat + 1;
          if (v.kind == 0) begin
            sa = $signed(v.a);
            sb = $signed(v.b);
            {ref_hi, ref_lo} = sa * sb;
          end else if (v.dz) begin
            ref_dz = 1'b1;
          end else begin
            ref_hi = v.a;
            ref_lo = v.b;
          end
        end
      end else begin
        if (v.kind != 3) ref_hi = v.a;
        if (v.kind != 2) ref_lo = v.a;
      end
      v.exp_hi = ref_hi;
      v.exp_lo = ref_lo;
      v.exp_dz = ref_dz;
      v.exp_to = ref_to;
      do_op(v, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
